// File: rtl/midori_ctrl_pkg.sv
// Shared constants and types for the three-share Midori64 sequencing controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package midori_ctrl_pkg;

   // Width of one Boolean share of the 64-bit state
   localparam int SHARE_W = 64;

   // Default datapath round-loop depth and keyed round count
   localparam int STAGE_CYC_DEF = 3;
   localparam int NR_ROUNDS_DEF = 15;

   // Round index presented during the final unkeyed S-box pass
   localparam logic [3:0] FINAL_ROUND = 4'd15;

   typedef logic [SHARE_W-1:0] share_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/midori_round_sequencer.sv
// Phase/round counters pacing the datapath: one round per STAGE_CYC cycles.
// Latency: counters step every cycle while advance is high; flags are combinational.
// Backpressure: none; clear has priority over advance and holds both counters at zero.
module midori_round_sequencer
   import midori_ctrl_pkg::*;
#(
   parameter int STAGE_CYC = STAGE_CYC_DEF,
   parameter int NR_ROUNDS = NR_ROUNDS_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       advance,
   output logic [3:0] round,
   output logic       last_phase,
   output logic       last_span
);

   localparam int              PH_W      = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
   localparam logic [PH_W-1:0] PH_LAST   = PH_W'(STAGE_CYC - 1);
   localparam logic [3:0]      SPAN_LAST = 4'(NR_ROUNDS);

   logic [PH_W-1:0] phase;

   assign last_phase = (phase == PH_LAST);
   assign last_span  = (round == SPAN_LAST);

   // Phase wraps every STAGE_CYC cycles; the round index steps on each wrap and
   // saturates at FINAL_ROUND so it can never alias back to a keyed round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
         round <= 4'd0;
      end else if (clear) begin
         phase <= '0;
         round <= 4'd0;
      end else if (advance) begin
         if (last_phase) begin
            phase <= '0;
            if (round != FINAL_ROUND) begin
               round <= round + 4'd1;
            end
         end else begin
            phase <= phase + PH_W'(1);
         end
      end
   end

endmodule

// File: rtl/midori_shared_ctrl.sv
// Sequencer for the three-share Midori64 round datapath: load, 16 spans, capture.
// Latency: done_o 1+(NR_ROUNDS+1)*STAGE_CYC+1 cycles after start_i is accepted (50 by default).
// Backpressure: start_i only sampled in IDLE; a held start_i re-issues every 51 cycles.
// Build option MIDORI_CTRL_WHITEN_EN: apply key whitening to share 1 on load and capture.
module midori_shared_ctrl
   import midori_ctrl_pkg::*;
#(
   parameter int STAGE_CYC = STAGE_CYC_DEF,
   parameter int NR_ROUNDS = NR_ROUNDS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [SHARE_W-1:0] pt_1_i,
   input  logic [SHARE_W-1:0] pt_2_i,
   input  logic [SHARE_W-1:0] pt_3_i,
   input  logic [SHARE_W-1:0] mk0_i,
   input  logic [SHARE_W-1:0] mk1_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [SHARE_W-1:0] ct_1_o,
   output logic [SHARE_W-1:0] ct_2_o,
   output logic [SHARE_W-1:0] ct_3_o,
   output logic [3:0]         dp_round_o,
   output logic               dp_start_sel_o,
   output logic [SHARE_W-1:0] dp_state_1_o,
   output logic [SHARE_W-1:0] dp_state_2_o,
   output logic [SHARE_W-1:0] dp_state_3_o,
   input  logic [SHARE_W-1:0] dp_ct_1_i,
   input  logic [SHARE_W-1:0] dp_ct_2_i,
   input  logic [SHARE_W-1:0] dp_ct_3_i
);

   ctrl_state_e state, state_nxt;
   share_t      pt_1_q, pt_2_q, pt_3_q;
   share_t      load_1, cap_1;
   logic        last_phase, last_span, capture;

   assign capture = (state == ST_RUN) && last_span && last_phase;

   // Only share 1 ever sees key material; shares 2 and 3 pass through untouched.
`ifdef MIDORI_CTRL_WHITEN_EN
   share_t wk;
   assign wk     = mk0_i ^ mk1_i;
   assign load_1 = pt_1_q ^ wk;
   assign cap_1  = dp_ct_1_i ^ wk;
`else
   logic unused_key;
   assign unused_key = ^{mk0_i, mk1_i};
   assign load_1     = pt_1_q;
   assign cap_1      = dp_ct_1_i;
`endif

   midori_round_sequencer #(
      .STAGE_CYC (STAGE_CYC),
      .NR_ROUNDS (NR_ROUNDS)
   ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (state != ST_RUN),
      .advance    (state == ST_RUN),
      .round      (dp_round_o),
      .last_phase (last_phase),
      .last_span  (last_span)
   );

   // Next-state: IDLE -> LOAD -> RUN (all spans) -> DONE -> IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_i) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_RUN;
         ST_RUN:  if (capture) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Input shares are latched only on acceptance, each into its own register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pt_1_q <= '0;
         pt_2_q <= '0;
         pt_3_q <= '0;
      end else if ((state == ST_IDLE) && start_i) begin
         pt_1_q <= pt_1_i;
         pt_2_q <= pt_2_i;
         pt_3_q <= pt_3_i;
      end
   end

   // Ciphertext shares update only on the final phase, so a partial result is never visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ct_1_o <= '0;
         ct_2_o <= '0;
         ct_3_o <= '0;
      end else if (capture) begin
         ct_1_o <= cap_1;
         ct_2_o <= dp_ct_2_i;
         ct_3_o <= dp_ct_3_i;
      end
   end

   assign busy_o         = (state != ST_IDLE);
   assign done_o         = (state == ST_DONE);
   assign dp_start_sel_o = (state == ST_LOAD);

   // Plaintext shares are gated to zero unless the datapath is actually loading them
   assign dp_state_1_o = dp_start_sel_o ? load_1 : '0;
   assign dp_state_2_o = dp_start_sel_o ? pt_2_q : '0;
   assign dp_state_3_o = dp_start_sel_o ? pt_3_q : '0;

endmodule

// File: doc/midori_shared_ctrl.md
# midori_shared_ctrl

Sequencing controller for the three-share threshold-implemented Midori64 round datapath. Accepts a shared plaintext and master key over a start/done handshake and loads the datapath's share registers. Drives the round index and load select for 15 keyed rounds plus the final S-box pass, then captures the three ciphertext shares into held output registers. Sits between the system bus wrapper and the datapath, which is instantiated beside it in the top level.

## Interface
- STAGE_CYC, 3: register stages in the datapath round loop (select register + nonlinear pipeline); cycles per round
- NR_ROUNDS, 15: keyed rounds before the final S-box pass
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  request an encryption; sampled only in IDLE
- pt_1_i / pt_2_i / pt_3_i  in  64 each  plaintext shares; must be stable in the cycle start_i is accepted
- mk0_i, mk1_i  in  64 each  master-key halves (unshared); stable from accept until done_o
- busy_o  out  1  high from accept until the cycle after capture
- done_o  out  1  one-cycle pulse; ct_* valid from this cycle on
- ct_1_o / ct_2_o / ct_3_o  out  64 each  registered ciphertext shares, held until the next capture
- dp_round_o  out  4  round index to the datapath
- dp_start_sel_o  out  1  datapath share-register load select
- dp_state_1_o / dp_state_2_o / dp_state_3_o  out  64 each  initial shares to the datapath
- dp_ct_1_i / dp_ct_2_i / dp_ct_3_i  in  64 each  datapath nonlinear-layer outputs

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: if start_i is high, latch pt_* into the input-share registers and go to LOAD. start_i is ignored in every other state.
- LOAD (1 cycle): dp_start_sel_o=1. dp_state_*_o carry the latched shares and are captured by the datapath at the end of the cycle. Clear the phase counter and round counter. Go to RUN.
- RUN: phase counts 0..STAGE_CYC-1 and wraps. The round counter increments on wrap. dp_round_o = round counter, held constant for the whole STAGE_CYC-cycle span.
  - Spans 0..NR_ROUNDS-1 are keyed rounds.
  - Span NR_ROUNDS (dp_round_o=15) is the final S-box pass.
  - In the last phase of span NR_ROUNDS, capture dp_ct_*_i into ct_* and go to DONE.
- DONE (1 cycle): done_o=1, then go to IDLE.
- dp_start_sel_o=0 in every state except LOAD.
- dp_state_*_o are driven to zero outside LOAD, so no plaintext share reaches the datapath mux unless it is selected.
- Shares are never recombined inside the block. Each share path is kept separate; only share 1 is touched by key material.
- Counter widths: phase uses $clog2(STAGE_CYC) bits; the round counter is 4 bits and never exceeds 15.

## Timing
- Reset: busy_o=0, done_o=0, ct_*=0, dp_round_o=0, dp_start_sel_o=0, dp_state_*=0, state=IDLE.
- Latency: start_i accepted at cycle 0, LOAD at cycle 1, capture at cycle 1+(NR_ROUNDS+1)·STAGE_CYC, done_o one cycle later. With the defaults, capture is at cycle 49 and done_o at cycle 50.
- Back-to-back: start_i held high through DONE is accepted in the following IDLE cycle; minimum issue interval is 51 cycles.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. Partial ct_* is never exposed.

## Configuration
- MIDORI_CTRL_WHITEN_EN defined:
  - In LOAD, dp_state_1_o = pt_1 XOR (mk0_i XOR mk1_i).
  - At capture, ct_1 = dp_ct_1_i XOR (mk0_i XOR mk1_i).
  - ct_* are full Midori64 ciphertext shares.
- Not defined: both whitenings are omitted; pt_1 and dp_ct_1_i pass through raw and the system wrapper applies whitening.

## Structure
- Package midori_ctrl_pkg: state enum, FINAL_ROUND=4'd15, the 64-bit share width constant, default STAGE_CYC/NR_ROUNDS.
- One sub-module, midori_round_sequencer: the phase counter and round counter with wrap, clear and last-span/last-phase flags. The FSM, share registers and optional whitening stay at top level.

## Test plan
- Test vector, MIDORI_CTRL_WHITEN_EN defined:
  - Stimulus: mk0=687ded3b3c85b3f3, mk1=5b1009863e2a8cbf, pt=42c20fd3b586879e split with random pt_2 and pt_3.
  - Required: done_o at cycle 50, ct_1^ct_2^ct_3 = 66bcdc6270d901cd.
- Same vector, macro undefined, bench applies whitening:
  - Stimulus: pt_1 pre-whitened by the bench.
  - Required: ct_1^ct_2^ct_3 XOR (mk0^mk1) = 66bcdc6270d901cd.
- Sequencing trace:
  - dp_start_sel_o high only at cycle 1.
  - dp_round_o steps 0,1,…,15, each value held exactly 3 cycles.
  - dp_state_* are 0 outside cycle 1.
- start_i pulsed at cycles 10 and 30 during a run -> ignored; exactly one done_o, ct unchanged until capture.
- rst_n dropped at cycle 20 and released -> outputs zero immediately; a new start completes correctly with done_o 50 cycles after acceptance.
- start_i held high continuously -> done_o every 51 cycles; ct_* stable between pulses.
